// File: rtl/xs_pkg.sv
// Shared types and constants for the xs_arbiter slice (requester index, state encoding,
// saturating grant-counter helper used when XS_ARB_CNT_EN is defined).
package xs_pkg;
   localparam int XS_NREQ  = 2;
   localparam int XS_CNT_W = 8;

   typedef logic xs_id_t;

   typedef enum logic {
      XS_EMPTY = 1'b0,
      XS_FULL  = 1'b1
   } xs_state_e;

   function automatic logic [XS_CNT_W-1:0] xs_sat_inc(input logic [XS_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/xs_alu.sv
// Shared XOR / conditional-shift unit: r = a ^ b, shifted left by one when a's MSB is set.
module xs_alu #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] res_o
);
   logic [WIDTH-1:0] r;

   assign r     = a_i ^ b_i;
   assign res_o = a_i[WIDTH-1] ? {r[WIDTH-2:0], 1'b0} : r;
endmodule

// File: rtl/xs_arbiter.sv
// Two-requester round-robin arbiter feeding one xs_alu into a single-entry result register.
// Optional per-requester saturating grant counters are built when XS_ARB_CNT_EN is defined.
//
// state    | meaning
// XS_EMPTY | no result held, any valid request is granted
// XS_FULL  | result held until downstream accepts it
module xs_arbiter
   import xs_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [XS_NREQ-1:0]       req_valid,
   output logic [XS_NREQ-1:0]       req_ready,
   input  logic [XS_NREQ*WIDTH-1:0] req_a,
   input  logic [XS_NREQ*WIDTH-1:0] req_b,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res_data,
   output xs_id_t                   res_id,
   output logic                     busy
`ifdef XS_ARB_CNT_EN
   ,
   output logic [XS_NREQ*XS_CNT_W-1:0] grant_cnt
`endif
);
   xs_state_e        state_q;
   logic [WIDTH-1:0] data_q;
   xs_id_t           id_q;
   xs_id_t           last_q;

   xs_id_t           sel;
   logic             can_accept;
   logic             grant;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_res;

   // Under contention the requester that did not win last time goes next.
   always_comb begin
      sel = 1'b0;
      if (&req_valid)
         sel = ~last_q;
      else if (req_valid[1])
         sel = 1'b1;
   end

   assign can_accept = (state_q == XS_EMPTY) || res_ready;
   assign grant      = (|req_valid) && can_accept && !rst;
   assign req_ready  = {XS_NREQ{grant}} & (XS_NREQ'(1) << sel);

   assign op_a = sel ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
   assign op_b = sel ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];

   xs_alu #(.WIDTH(WIDTH)) u_alu (
      .a_i   (op_a),
      .b_i   (op_b),
      .res_o (alu_res)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= XS_EMPTY;
         data_q  <= '0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
      end else if (grant) begin
         state_q <= XS_FULL;
         data_q  <= alu_res;
         id_q    <= sel;
         last_q  <= sel;
      end else if (res_ready) begin
         state_q <= XS_EMPTY;
      end
   end

   assign res_valid = (state_q == XS_FULL);
   assign busy      = res_valid;
   assign res_data  = data_q;
   assign res_id    = id_q;

`ifdef XS_ARB_CNT_EN
   logic [XS_CNT_W-1:0] cnt_q [XS_NREQ];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < XS_NREQ; i++)
            cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < XS_NREQ; i++)
            if (req_ready[i])
               cnt_q[i] <= xs_sat_inc(cnt_q[i]);
      end
   end

   assign grant_cnt = {cnt_q[1], cnt_q[0]};
`endif
endmodule

// File: tb/tb_xs_arbiter.sv
// Scoreboard bench for xs_arbiter: driver issues requests and pushes expected results,
// a separate monitor pops and compares on every result handshake.
module tb_xs_arbiter;
   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_data;
   logic        res_id;
   logic        busy;
`ifdef XS_ARB_CNT_EN
   logic [15:0] grant_cnt;
`endif

   xs_arbiter #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .busy      (busy)
`ifdef XS_ARB_CNT_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int checks      = 0;

   logic [8:0] sb_q[$];   // {id, data}
   bit         mdl_full;
   int         mdl_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_xs(input logic [7:0] a, input logic [7:0] b);
      int r;
      r = int'(a ^ b);
      if (a >= 8'h80) r = (r * 2) % 256;
      return 8'(r);
   endfunction

   // Called at posedge+1; returns at the next posedge+1.
   task automatic step(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic rr,
                       output logic [1:0] g);
      int   pick;
      bit   can;
      logic [1:0] exp_rdy;
      req_valid = v;
      req_a     = {a1, a0};
      req_b     = {b1, b0};
      res_ready = rr;
      #3;
      can = !mdl_full || rr;
      if (v == 2'b11) pick = 1 - mdl_last;
      else if (v[0])  pick = 0;
      else            pick = 1;
      exp_rdy = (v != 2'b00 && can) ? ((pick == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk("req_ready", req_ready, exp_rdy);
      chk("res_valid", res_valid, mdl_full);
      chk("busy", busy, mdl_full);
      if (mdl_full && sb_q.size() > 0) begin
         chk("held_data", res_data, sb_q[0][7:0]);
         chk("held_id", res_id, sb_q[0][8]);
      end
      if (exp_rdy != 2'b00) begin
         sb_q.push_back({pick[0], (pick == 0) ? ref_xs(a0, b0) : ref_xs(a1, b1)});
         mdl_last = pick;
         mdl_full = 1;
      end else if (rr) begin
         mdl_full = 0;
      end
      g = exp_rdy;
      vectors++;
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle; called at posedge+1.
   task automatic mid_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_id", res_id, 0);
      sb_q.delete();
      mdl_full  = 0;
      mdl_last  = 1;
      req_valid = 2'b11;
      res_ready = 1'b1;
      #2;
      chk("rst_no_grant", req_ready, 0);
      @(posedge clk);
      #1;
      chk("rst_held_empty", res_valid, 0);
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_result: got data %0h id %0h expected none", res_data, res_id);
         end else begin
            logic [8:0] e;
            e = sb_q.pop_front();
            chk("res_data", res_data, e[7:0]);
            chk("res_id", res_id, e[8]);
         end
      end
   end

   initial begin
      logic [1:0] g;
      logic [1:0] rv;
      logic [7:0] ra [2];
      logic [7:0] rb [2];
      int         n;

      rst = 1'b1; req_valid = 2'b00; req_a = '0; req_b = '0; res_ready = 1'b0;
      mdl_full = 0; mdl_last = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_res_valid", res_valid, 0);
      chk("reset_res_data", res_data, 0);
      chk("reset_res_id", res_id, 0);
      chk("reset_busy", busy, 0);
`ifdef XS_ARB_CNT_EN
      chk("reset_grant_cnt", grant_cnt, 0);
`endif

      step(2'b01, 8'h0F, 8'h3C, 8'h00, 8'h00, 1'b1, g);
      chk("single_ready", g, 2'b01);
      chk("single_data", res_data, 8'h33);
      chk("single_id", res_id, 0);
      step(2'b10, 8'h00, 8'h00, 8'hC3, 8'h00, 1'b1, g);
      chk("shift_data", res_data, 8'h86);
      chk("shift_id", res_id, 1);
      step(2'b10, 8'h00, 8'h00, 8'h81, 8'h01, 1'b1, g);
      chk("shift_zero_data", res_data, 8'h00);
      step(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, g);

      mid_reset();
      for (int i = 0; i < 4; i++) begin
         step(2'b11, 8'(i), 8'h5A, 8'(i + 8'h80), 8'hA5, 1'b1, g);
         chk("contention_grant", g, (i % 2 == 0) ? 2'b01 : 2'b10);
         chk("contention_id", res_id, i % 2);
      end

      for (int i = 0; i < 3; i++) begin
         step(2'b11, 8'h11, 8'h22, 8'h93, 8'h44, 1'b0, g);
         chk("stall_no_grant", g, 2'b00);
      end
      step(2'b11, 8'h11, 8'h22, 8'h93, 8'h44, 1'b1, g);
      chk("stall_release_grant", g, 2'b01);
      chk("stall_release_id", res_id, 0);

      mid_reset();
      step(2'b11, 8'hF0, 8'h0F, 8'h01, 8'h02, 1'b1, g);
      chk("post_reset_first", g, 2'b01);

      rv = 2'b00; g = 2'b00;
      ra[0] = 0; ra[1] = 0; rb[0] = 0; rb[1] = 0;
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < 2; i++) begin
            if (!(rv[i] && !g[i])) begin
               rv[i] = 1'($urandom_range(0, 1));
               ra[i] = 8'($urandom);
               rb[i] = 8'($urandom);
            end
         end
         step(rv, ra[0], rb[0], ra[1], rb[1], ($urandom_range(0, 9) < 7), g);
      end

`ifdef XS_ARB_CNT_EN
      mid_reset();
      chk("cnt_after_reset", grant_cnt, 0);
      for (int k = 0; k < 300; k++)
         step(2'b01, 8'(k), 8'h3C, 8'h00, 8'h00, 1'b1, g);
      chk("cnt_saturated", grant_cnt, 16'h00FF);
`endif

      n = 0;
      while (sb_q.size() != 0 && n < 10) begin
         step(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, g);
         n++;
      end
      chk("scoreboard_drained", sb_q.size(), 0);
      chk("final_idle", res_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
